// File: rtl/bitonic_sort_ctrl.sv
// bitonic_sort_ctrl: gamma-cycle sequencer for the 4-input temporal bitonic sorter.
//
// The sequencer replays four binary time values as 1->0 transitions on the
// sorter inputs, one unit time per clock. It watches the sorter outputs on
// every tick and records the tick on which each rank falls, earliest first.
//
// Parameters:
//   TW    - width of one time value
//   TMAX  - last tick of the gamma window (<= 2^TW-1); t >= TMAX means "no spike"
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to sort in_time (honoured only when idle)
//   in_time    in   input i time at [i*TW +: TW]
//   busy       out  high while a gamma cycle is in progress (ARM/RUN/DONE)
//   line_out   out  drives sorter raw_in; idle level 4'b1111
//   sorted_in  in   sorter sorted_out; rank 0 = earliest fall
//   rank_time  out  rank j time at [j*TW +: TW]; held until next accepted start
//   done       out  one-cycle pulse when rank_time is final
//   err        out  sticky sorter-order fault, cleared on accepted start
//
// Build option:
//   SORT_CTRL_CHECK_EN - when defined, compiles in the sorter order checker that
//                        drives err; otherwise err is tied low.

module bitonic_sort_ctrl #(
  parameter int unsigned TW   = 3,
  parameter int unsigned TMAX = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4*TW-1:0] in_time,
  output logic            busy,
  output logic [3:0]      line_out,
  input  logic [3:0]      sorted_in,
  output logic [4*TW-1:0] rank_time,
  output logic            done,
  output logic            err
);

  localparam logic [TW-1:0] TMaxV = TW'(TMAX);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [4*TW-1:0]   in_time_q, in_time_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [3:0]        latched_q, latched_d;
  logic [4*TW-1:0]   rank_time_q, rank_time_d;
  logic              last_tick;
  logic              accept;

  assign last_tick = (tick_q == TMaxV);
  assign accept    = (state_q == StIdle) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_time_q   <= '0;
      tick_q      <= '0;
      latched_q   <= '0;
      rank_time_q <= '0;
    end else begin
      state_q     <= state_d;
      in_time_q   <= in_time_d;
      tick_q      <= tick_d;
      latched_q   <= latched_d;
      rank_time_q <= rank_time_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_time_d   = in_time_q;
    tick_d      = tick_q;
    latched_d   = latched_q;
    rank_time_d = rank_time_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          in_time_d   = in_time;
          rank_time_d = '0;
          latched_d   = '0;
          state_d     = StArm;
        end
      end

      StArm: begin
        tick_d  = '0;
        state_d = StRun;
      end

      StRun: begin
        // On the last tick every still-unlatched rank takes tick==TMAX, so
        // rank_time is already final while done is high.
        for (int j = 0; j < 4; j++) begin
          if (!latched_q[j] && (!sorted_in[j] || last_tick)) begin
            rank_time_d[j*TW +: TW] = tick_q;
            latched_d[j]            = 1'b1;
          end
        end
        if (last_tick) begin
          state_d = StDone;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      StDone: begin
        for (int j = 0; j < 4; j++) begin
          if (!latched_q[j]) begin
            rank_time_d[j*TW +: TW] = TMaxV;
            latched_d[j]            = 1'b1;
          end
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from registered state only, so the combinational
  // sorter loop line_out -> sorted_in never feeds back into line_out.
  always_comb begin
    line_out = 4'b1111;
    if (state_q == StRun) begin
      for (int i = 0; i < 4; i++) begin
        line_out[i] = (in_time_q[i*TW +: TW] >= TMaxV) || (tick_q < in_time_q[i*TW +: TW]);
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign rank_time = rank_time_q;

`ifdef SORT_CTRL_CHECK_EN
  logic err_q, err_d;
  logic order_fault;
  logic rise_fault;

  // A lower rank may never be later than a higher one, and a fallen rank
  // may never recover within the window.
  assign order_fault = |(~sorted_in[3:1] & sorted_in[2:0]);
  assign rise_fault  = |(latched_q & sorted_in);

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == StRun) && (order_fault || rise_fault)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: doc/bitonic_sort_ctrl.md
# bitonic_sort_ctrl

Gamma-cycle sequencer for the 4-input bitonic sorter (`bitonic_sort_4`). It takes four binary time values and replays them as 1->0 transitions on the sorter inputs, one unit time per clock. It samples the sorter outputs every tick and records the arrival time of each rank, earliest first. It sits between the register-level front end and the combinational temporal sorter, and returns rank-ordered times with a done pulse.

## Interface
Parameters:
- `TW`, 3 — width of one time value.
- `TMAX`, 7 — last tick of the gamma window; must be ≤ 2^TW−1. A time value ≥ TMAX means "no spike".

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle request to sort `in_time`; honoured only in IDLE.
- `in_time` in 4*TW — input i at `[i*TW +: TW]`.
- `busy` out 1 — high in ARM, RUN and DONE.
- `line_out` out 4 — drives sorter `raw_in`; idle level 1.
- `sorted_in` in 4 — from sorter `sorted_out`; rank 0 = earliest fall.
- `rank_time` out 4*TW — rank j time at `[j*TW +: TW]`; held until next start.
- `done` out 1 — one-cycle pulse when `rank_time` is final.
- `err` out 1 — sticky sorter-order fault; cleared on accepted start.

## Operation
- **Reset values:** state IDLE, `line_out`=4'b1111, `rank_time`=0, `done`=0, `busy`=0, `err`=0, tick=0, latched flags=0.
- **IDLE:**
  - `start`=1 captures `in_time` into an internal register.
  - Clears `rank_time`, latched flags and `err`.
  - Goes to ARM.
- **ARM (1 cycle):**
  - `line_out`=1111, tick=0.
  - Goes to RUN.
- **RUN:**
  - Per input i: `line_out[i]` = (tick < t_i) ? 1 : 0.
  - An input with t_i=0 falls on the first RUN cycle. An input with t_i ≥ TMAX never falls.
  - Each cycle, for each rank j not yet latched: if `sorted_in[j]`=0, set `rank_time[j]` = tick and mark rank j latched.
  - The sorter is combinational, so `sorted_in` is sampled in the same cycle `line_out` changes.
  - tick increments each cycle. After the tick==TMAX cycle, go to DONE.
- **DONE (1 cycle):**
  - `done`=1.
  - Each unlatched rank gets `rank_time[j]` = TMAX.
  - `line_out` returns to 1111.
  - Goes to IDLE.
- **Ties:** equal t_i fall in the same tick, so those ranks latch the same value.
- **start while busy:** ignored; no queueing.
- **Reset mid-operation:** immediate return to reset values on the next edge; no done pulse.
- **Arithmetic:** tick is TW bits wide and never wraps, because RUN ends at TMAX. Compare t_i ≥ TMAX unsigned.

## Timing
- `start` is sampled at edge 0 → ARM during cycle 1.
- RUN ticks 0..TMAX occupy cycles 2..TMAX+2.
- `done` is high in cycle TMAX+3.
- The earliest next `start` is accepted at the edge ending cycle TMAX+3 + 1, i.e. once back in IDLE. Fixed latency is TMAX+3 cycles from start to done (10 for TMAX=7).
- `rank_time` bits are stable from the `done` cycle until the next accepted start.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Configuration
- **`SORT_CTRL_CHECK_EN` defined:** sorter order checker compiled in. During RUN, `err` is set and held if either of these occurs:
  - `sorted_in[j]`=0 while `sorted_in[j-1]`=1 (j=1..3);
  - a latched rank's `sorted_in` line returns to 1.
- **`SORT_CTRL_CHECK_EN` undefined:** `err` is tied 0 and the checker logic is absent. Sequencing is otherwise identical.

## Test plan
All scenarios use TMAX=7, TW=3.
1. **Basic sort:** `in_time` (i0..i3)={3,1,2,0}, start at cycle 0 → `rank_time`={0,1,2,3}, `done` high exactly at cycle 10, `busy` high cycles 1–10, `err`=0.
2. **Ties:** all inputs 5 → all ranks 5. `line_out` stays 1111 through tick 4 and is 0000 from tick 5.
3. **Null spikes:** {7,7,2,7} → rank0=2, ranks1–3=7. `line_out`[0,1,3] never fall.
4. **Busy and reset:**
   - A second `start` with different data at cycle 4 → ignored; results match the first data.
   - Separately, `rst` asserted at RUN tick 3 → next cycle all outputs at reset values, no `done`.
5. **Fault injection (`SORT_CTRL_CHECK_EN` defined):** the bench overrides `sorted_in` so rank1 falls at tick 2 while rank0 is still 1 → `err`=1 from the next cycle, held through `done`, cleared on the next accepted start. With the macro undefined, `err` stays 0.
